// File: rtl/if_id_hazard_reg.sv
// if_id_hazard_reg: IF/ID pipeline register with load-use stall and branch-flush control.
// Latency: one cycle from pc_in/instr_in to pc_out/instr_out. A load-use stall holds the
// register (and the PC) for exactly one cycle; a taken branch squashes it to a bubble.
//
// Ports:
//   clk, reset            clock; synchronous active-low reset
//   pc_in, instr_in       fetched PC / instruction
//   branch_taken          branch resolved taken in EX/MEM
//   idex_memread, idex_rd load in ID/EX and its destination register
//   pc_out, instr_out,
//   valid_out             registered instruction and its valid flag
//   rs1, rs2, rd,
//   funct4, opcode        pre-decoded fields of instr_out
//   pc_write, ifid_write,
//   flush_idex            combinational pipeline controls
//   stall_cnt, flush_cnt,
//   issue_cnt             saturating performance counters
module if_id_hazard_reg #(
  parameter int                 PC_W      = 64,
  parameter int                 INSTR_W   = 32,
  parameter int                 CNT_W     = 16,
  parameter logic [INSTR_W-1:0] NOP_INSTR = 32'h00000013
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [PC_W-1:0]    pc_in,
  input  logic [INSTR_W-1:0] instr_in,
  input  logic               branch_taken,
  input  logic               idex_memread,
  input  logic [4:0]         idex_rd,
  output logic [PC_W-1:0]    pc_out,
  output logic [INSTR_W-1:0] instr_out,
  output logic               valid_out,
  output logic [4:0]         rs1,
  output logic [4:0]         rs2,
  output logic [4:0]         rd,
  output logic [3:0]         funct4,
  output logic [6:0]         opcode,
  output logic               pc_write,
  output logic               ifid_write,
  output logic               flush_idex,
  output logic [CNT_W-1:0]   stall_cnt,
  output logic [CNT_W-1:0]   flush_cnt,
  output logic [CNT_W-1:0]   issue_cnt
);

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    BUBBLE = 2'd1,
    FLUSH  = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t state;
  logic   uses_rs1;
  logic   uses_rs2;
  logic   hz;

  // Field decode is a pure slice of the registered instruction.
  assign rs1    = instr_out[19:15];
  assign rs2    = instr_out[24:20];
  assign rd     = instr_out[11:7];
  assign funct4 = {instr_out[30], instr_out[14:12]};
  assign opcode = instr_out[6:0];

  // R-type, I-type ALU, load, store and branch read rs1; only R, store and branch read rs2.
  always_comb begin
    uses_rs1 = 1'b0;
    uses_rs2 = 1'b0;
    case (opcode)
      7'b0110011: begin uses_rs1 = 1'b1; uses_rs2 = 1'b1; end
      7'b0010011: uses_rs1 = 1'b1;
      7'b0000011: uses_rs1 = 1'b1;
      7'b0100011: begin uses_rs1 = 1'b1; uses_rs2 = 1'b1; end
      7'b1100011: begin uses_rs1 = 1'b1; uses_rs2 = 1'b1; end
      default: ;
    endcase
  end

  // Masked in BUBBLE so the same load-use pair can never stall twice.
  assign hz = valid_out && (state != BUBBLE) && idex_memread && (idex_rd != 5'd0) &&
              ((uses_rs1 && (idex_rd == rs1)) || (uses_rs2 && (idex_rd == rs2)));

  // Priority: reset > branch flush > load-use stall > normal advance.
  always_comb begin
    pc_write   = 1'b1;
    ifid_write = 1'b1;
    flush_idex = 1'b0;
    if (!reset) begin
      ifid_write = 1'b0;
      flush_idex = 1'b1;
    end else if (branch_taken) begin
      flush_idex = 1'b1;
    end else if (hz) begin
      pc_write   = 1'b0;
      ifid_write = 1'b0;
      flush_idex = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      pc_out    <= '0;
      instr_out <= NOP_INSTR;
      valid_out <= 1'b0;
      state     <= RUN;
      stall_cnt <= '0;
      flush_cnt <= '0;
      issue_cnt <= '0;
    end else begin
      if (branch_taken) begin
        pc_out    <= '0;
        instr_out <= NOP_INSTR;
        valid_out <= 1'b0;
        state     <= FLUSH;
        if (flush_cnt != CNT_MAX) flush_cnt <= flush_cnt + CNT_ONE;
      end else if (hz) begin
        // pc_out/instr_out/valid_out hold; ID/EX receives a bubble.
        state <= BUBBLE;
        if (stall_cnt != CNT_MAX) stall_cnt <= stall_cnt + CNT_ONE;
      end else begin
        pc_out    <= pc_in;
        instr_out <= instr_in;
        valid_out <= 1'b1;
        state     <= RUN;
      end

      // An instruction is issued when it leaves this stage un-squashed.
      if (valid_out && !flush_idex && (issue_cnt != CNT_MAX))
        issue_cnt <= issue_cnt + CNT_ONE;
    end
  end

endmodule

// File: tb/tb_if_id_hazard_reg.sv
module tb_if_id_hazard_reg;

  localparam logic [31:0] NOP  = 32'h00000013;
  localparam logic [31:0] ADDI = 32'h00500093; // addi x1,x0,5
  localparam logic [31:0] ADD  = 32'h00208133; // add  x2,x1,x2
  localparam logic [31:0] ADDI2= 32'h00208113; // addi x2,x1,2

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // main instance (default parameters)
  logic        reset, branch_taken, idex_memread;
  logic [63:0] pc_in;
  logic [31:0] instr_in;
  logic [4:0]  idex_rd;
  logic [63:0] pc_out;
  logic [31:0] instr_out;
  logic        valid_out, pc_write, ifid_write, flush_idex;
  logic [4:0]  rs1, rs2, rd;
  logic [3:0]  funct4;
  logic [6:0]  opcode;
  logic [15:0] stall_cnt, flush_cnt, issue_cnt;

  if_id_hazard_reg dut (
    .clk(clk), .reset(reset), .pc_in(pc_in), .instr_in(instr_in),
    .branch_taken(branch_taken), .idex_memread(idex_memread), .idex_rd(idex_rd),
    .pc_out(pc_out), .instr_out(instr_out), .valid_out(valid_out),
    .rs1(rs1), .rs2(rs2), .rd(rd), .funct4(funct4), .opcode(opcode),
    .pc_write(pc_write), .ifid_write(ifid_write), .flush_idex(flush_idex),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt), .issue_cnt(issue_cnt)
  );

  // narrow-counter instance so saturation is reachable in a short run
  logic        s_reset, s_branch, s_memread;
  logic [63:0] s_pc_in;
  logic [31:0] s_instr_in;
  logic [4:0]  s_idex_rd;
  logic [63:0] s_pc_out;
  logic [31:0] s_instr_out;
  logic        s_valid, s_pc_write, s_ifid_write, s_flush;
  logic [4:0]  s_rs1, s_rs2, s_rd;
  logic [3:0]  s_funct4;
  logic [6:0]  s_opcode;
  logic [3:0]  s_stall, s_flush_cnt, s_issue;

  if_id_hazard_reg #(.CNT_W(4)) sdut (
    .clk(clk), .reset(s_reset), .pc_in(s_pc_in), .instr_in(s_instr_in),
    .branch_taken(s_branch), .idex_memread(s_memread), .idex_rd(s_idex_rd),
    .pc_out(s_pc_out), .instr_out(s_instr_out), .valid_out(s_valid),
    .rs1(s_rs1), .rs2(s_rs2), .rd(s_rd), .funct4(s_funct4), .opcode(s_opcode),
    .pc_write(s_pc_write), .ifid_write(s_ifid_write), .flush_idex(s_flush),
    .stall_cnt(s_stall), .flush_cnt(s_flush_cnt), .issue_cnt(s_issue)
  );

  typedef struct {
    logic        rst;
    logic [63:0] pc;
    logic [31:0] ins;
    logic        br;
    logic        mr;
    logic [4:0]  rdx;
    logic        pw;   // expected combinational controls before the edge
    logic        iw;
    logic        fl;
    logic [63:0] e_pc; // expected registered values after the edge
    logic [31:0] e_ins;
    logic        e_v;
    logic [15:0] e_st;
    logic [15:0] e_fl;
    logic [15:0] e_is;
  } vec_t;

  vec_t vq[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   cur     = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s step%0d: got %0h expected %0h", name, cur, act, exp);
    end
  endtask

  initial begin
    logic [31:0] ei;
    reset = 1'b0; pc_in = '0; instr_in = NOP; branch_taken = 1'b0;
    idex_memread = 1'b0; idex_rd = '0;
    s_reset = 1'b0; s_pc_in = 64'h100; s_instr_in = NOP; s_branch = 1'b0;
    s_memread = 1'b0; s_idex_rd = '0;

    //            rst  pc       ins    br   mr   rd    pw   iw   fl   e_pc     e_ins  v    st  fl  is
    vq.push_back('{1'b0,64'h40, ADDI, 1'b0,1'b0,5'd0, 1'b1,1'b0,1'b1, 64'h0,  NOP,  1'b0,16'd0,16'd0,16'd0}); // 0 reset
    vq.push_back('{1'b0,64'h40, ADDI, 1'b0,1'b0,5'd0, 1'b1,1'b0,1'b1, 64'h0,  NOP,  1'b0,16'd0,16'd0,16'd0}); // 1 reset
    vq.push_back('{1'b1,64'h40, ADDI, 1'b0,1'b0,5'd0, 1'b1,1'b1,1'b0, 64'h40, ADDI, 1'b1,16'd0,16'd0,16'd0}); // 2 first load
    vq.push_back('{1'b1,64'h44, ADD,  1'b0,1'b0,5'd0, 1'b1,1'b1,1'b0, 64'h44, ADD,  1'b1,16'd0,16'd0,16'd1}); // 3 issue=1
    vq.push_back('{1'b1,64'h48, ADDI, 1'b0,1'b1,5'd1, 1'b0,1'b0,1'b1, 64'h44, ADD,  1'b1,16'd1,16'd0,16'd1}); // 4 load-use rs1
    vq.push_back('{1'b1,64'h48, ADDI, 1'b0,1'b1,5'd1, 1'b1,1'b1,1'b0, 64'h48, ADDI, 1'b1,16'd1,16'd0,16'd2}); // 5 BUBBLE masks hz
    vq.push_back('{1'b1,64'h4C, ADDI2,1'b0,1'b1,5'd0, 1'b1,1'b1,1'b0, 64'h4C, ADDI2,1'b1,16'd1,16'd0,16'd3}); // 6 rd=0 no stall
    vq.push_back('{1'b1,64'h50, ADD,  1'b0,1'b1,5'd2, 1'b1,1'b1,1'b0, 64'h50, ADD,  1'b1,16'd1,16'd0,16'd4}); // 7 I-type rs2 field
    vq.push_back('{1'b1,64'h54, ADDI, 1'b1,1'b1,5'd1, 1'b1,1'b1,1'b1, 64'h0,  NOP,  1'b0,16'd1,16'd1,16'd4}); // 8 branch beats hz
    vq.push_back('{1'b1,64'h58, ADDI, 1'b1,1'b0,5'd0, 1'b1,1'b1,1'b1, 64'h0,  NOP,  1'b0,16'd1,16'd2,16'd4}); // 9 back-to-back
    vq.push_back('{1'b1,64'h5C, ADD,  1'b0,1'b0,5'd0, 1'b1,1'b1,1'b0, 64'h5C, ADD,  1'b1,16'd1,16'd2,16'd4}); // 10 exit FLUSH
    vq.push_back('{1'b1,64'h60, ADDI, 1'b0,1'b1,5'd2, 1'b0,1'b0,1'b1, 64'h5C, ADD,  1'b1,16'd2,16'd2,16'd4}); // 11 load-use rs2
    vq.push_back('{1'b0,64'h60, ADDI, 1'b0,1'b1,5'd2, 1'b1,1'b0,1'b1, 64'h0,  NOP,  1'b0,16'd0,16'd0,16'd0}); // 12 reset mid-stall
    vq.push_back('{1'b1,64'h64, ADD,  1'b0,1'b1,5'd1, 1'b1,1'b1,1'b0, 64'h64, ADD,  1'b1,16'd0,16'd0,16'd0}); // 13 valid=0 no hz
    vq.push_back('{1'b1,64'h68, ADDI, 1'b1,1'b1,5'd1, 1'b1,1'b1,1'b1, 64'h0,  NOP,  1'b0,16'd0,16'd1,16'd0}); // 14 flush
    vq.push_back('{1'b0,64'h6C, ADDI, 1'b0,1'b0,5'd0, 1'b1,1'b0,1'b1, 64'h0,  NOP,  1'b0,16'd0,16'd0,16'd0}); // 15 reset mid-flush
    vq.push_back('{1'b1,64'h70, ADDI, 1'b0,1'b0,5'd0, 1'b1,1'b1,1'b0, 64'h70, ADDI, 1'b1,16'd0,16'd0,16'd0}); // 16
    vq.push_back('{1'b1,64'h74, ADDI, 1'b0,1'b1,5'd5, 1'b1,1'b1,1'b0, 64'h74, ADDI, 1'b1,16'd0,16'd0,16'd1}); // 17 rs2 field, I-type

    for (int i = 0; i < vq.size(); i++) begin
      cur = i;
      @(negedge clk);
      reset = vq[i].rst; pc_in = vq[i].pc; instr_in = vq[i].ins;
      branch_taken = vq[i].br; idex_memread = vq[i].mr; idex_rd = vq[i].rdx;
      #1;
      check("pc_write",   {63'd0, pc_write},   {63'd0, vq[i].pw});
      check("ifid_write", {63'd0, ifid_write}, {63'd0, vq[i].iw});
      check("flush_idex", {63'd0, flush_idex}, {63'd0, vq[i].fl});
      @(posedge clk);
      #1;
      check("pc_out",    pc_out,              vq[i].e_pc);
      check("instr_out", {32'd0, instr_out},  {32'd0, vq[i].e_ins});
      check("valid_out", {63'd0, valid_out},  {63'd0, vq[i].e_v});
      check("stall_cnt", {48'd0, stall_cnt},  {48'd0, vq[i].e_st});
      check("flush_cnt", {48'd0, flush_cnt},  {48'd0, vq[i].e_fl});
      check("issue_cnt", {48'd0, issue_cnt},  {48'd0, vq[i].e_is});
      ei = vq[i].e_ins;
      check("rs1",    {59'd0, rs1},    {59'd0, ei[19:15]});
      check("rs2",    {59'd0, rs2},    {59'd0, ei[24:20]});
      check("rd",     {59'd0, rd},     {59'd0, ei[11:7]});
      check("funct4", {60'd0, funct4}, {60'd0, ei[30], ei[14:12]});
      check("opcode", {57'd0, opcode}, {57'd0, ei[6:0]});
    end

    // hand-decoded fields of sub x2,x1,x2 (bit 30 set)
    cur = 100;
    @(negedge clk);
    reset = 1'b1; branch_taken = 1'b0; idex_memread = 1'b0; instr_in = 32'h40208133; pc_in = 64'h78;
    @(posedge clk); #1;
    check("dec_rs1",    {59'd0, rs1},    64'd1);
    check("dec_rs2",    {59'd0, rs2},    64'd2);
    check("dec_rd",     {59'd0, rd},     64'd2);
    check("dec_funct4", {60'd0, funct4}, 64'd8);
    check("dec_opcode", {57'd0, opcode}, 64'h33);

    // saturation: repeated load-use pairs on the 4-bit-counter instance.
    // Edge 1 loads ADD; each even edge is a stall, each odd edge >=3 an issue.
    cur = 200;
    @(negedge clk);
    s_reset = 1'b1; s_instr_in = ADD; s_memread = 1'b1; s_idex_rd = 5'd1;
    repeat (29) @(posedge clk);
    #1;
    check("sat_stall_14", {60'd0, s_stall}, 64'd14);
    check("sat_issue_14", {60'd0, s_issue}, 64'd14);
    repeat (6) @(posedge clk);
    #1;
    cur = 201;
    check("sat_stall_max", {60'd0, s_stall}, 64'd15);
    check("sat_issue_max", {60'd0, s_issue}, 64'd15);
    check("sat_flush_0",   {60'd0, s_flush_cnt}, 64'd0);
    check("sat_valid",     {63'd0, s_valid}, 64'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/if_id_hazard_reg.md
Name: if_id_hazard_reg

Overview:
- IF/ID pipeline register for the 5-stage RV64 core. Sits between the fetch stage and the ID/EX register.
- Contains load-use hazard detection and branch-flush control:
  - drives PC write-enable;
  - drives the IF/ID hold;
  - drives flush_IDEX to the ID/EX register.
- Provides pre-decoded register fields and saturating performance counters (stalls, flushes, issued instructions).

Parameters:
- PC_W, 64, PC width
- INSTR_W, 32, instruction width
- CNT_W, 16, performance counter width
- NOP_INSTR, 32'h00000013, bubble instruction (addi x0,x0,0)

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-low reset
- pc_in  in  PC_W  PC of fetched instruction
- instr_in  in  INSTR_W  fetched instruction
- branch_taken  in  1  branch resolved taken (EX/MEM Branch2 & zero)
- idex_memread  in  1  MemRead2 from ID/EX
- idex_rd  in  5  Rd2 from ID/EX
- pc_out  out  PC_W  registered PC
- instr_out  out  INSTR_W  registered instruction
- valid_out  out  1  instr_out is a real instruction
- rs1  out  5  instr_out[19:15]
- rs2  out  5  instr_out[24:20]
- rd  out  5  instr_out[11:7]
- funct4  out  4  {instr_out[30], instr_out[14:12]}
- opcode  out  7  instr_out[6:0]
- pc_write  out  1  PC register enable (combinational)
- ifid_write  out  1  this register's load enable, exported for debug (combinational)
- flush_idex  out  1  to ID/EX flush_IDEX (combinational)
- stall_cnt  out  CNT_W  load-use bubbles inserted, saturating
- flush_cnt  out  CNT_W  branch flushes, saturating
- issue_cnt  out  CNT_W  valid instructions passed to ID/EX, saturating

Behaviour:
- Reset (reset==0 at posedge clk):
  - pc_out=0, instr_out=NOP_INSTR, valid_out=0;
  - state=RUN;
  - all counters 0.
- While reset==0, combinational outputs are pc_write=1, ifid_write=0, flush_idex=1.
- Field outputs (rs1, rs2, rd, funct4, opcode) are pure slices of instr_out.
- Register usage, decoded from opcode:
  - uses_rs1: opcode is 0110011, 0010011, 0000011, 0100011 or 1100011.
  - uses_rs2: opcode is 0110011, 0100011 or 1100011.
- Load-use hazard condition (hz) = valid_out & state!=BUBBLE & idex_memread & idex_rd!=0 & ((uses_rs1 & idex_rd==rs1) | (uses_rs2 & idex_rd==rs2)).
- FSM states: RUN, BUBBLE, FLUSH. Priority per cycle: reset > branch_taken > hz > normal.
  - branch_taken=1:
    - pc_write=1, ifid_write=1, flush_idex=1;
    - next edge: instr_out=NOP_INSTR, pc_out=0, valid_out=0;
    - state->FLUSH, flush_cnt++;
    - any simultaneous hz is ignored (no stall_cnt increment).
  - hz=1 (no branch):
    - pc_write=0, ifid_write=0, flush_idex=1;
    - pc_out/instr_out/valid_out hold;
    - state->BUBBLE, stall_cnt++.
  - Normal:
    - pc_write=1, ifid_write=1, flush_idex=0;
    - next edge: pc_out=pc_in, instr_out=instr_in, valid_out=1;
    - state->RUN.
- BUBBLE lasts exactly one cycle. hz is masked in BUBBLE, which guarantees one bubble per load-use pair. It exits via normal advance or a branch flush.
- FLUSH lasts one cycle (valid_out=0, so hz cannot fire). It exits to RUN, or re-enters FLUSH on another branch_taken.
- issue_cnt increments on any edge where reset==1, valid_out==1 and flush_idex==0.
- Counters saturate at all-ones and never wrap.
- Latency: 1 cycle from pc_in/instr_in to pc_out/instr_out.
- Reset mid-stall or mid-flush: state returns to RUN and the held instruction is discarded.

Test Plan:
- Reset: hold reset=0 for 2 cycles with pc_in=0x40, instr_in=0x00500093 -> instr_out=0x00000013, valid_out=0, all counters 0, flush_idex=1; after release, next edge gives pc_out=0x40, valid_out=1, issue_cnt=1 after the following edge.
- Load-use, rs1: instr_out=0x00208133 (add x2,x1,x2), idex_memread=1, idex_rd=1 -> pc_write=0, ifid_write=0, flush_idex=1 for exactly one cycle; state BUBBLE; stall_cnt=1; instr_out unchanged next cycle.
- No false hazard:
  - idex_rd=0 with idex_memread=1 -> no stall;
  - I-type 0x00208113 (addi x2,x1,2) with idex_rd=2 (its rs2-field value) -> no stall (uses_rs2=0).
- Branch beats hazard: branch_taken=1 and hz=1 in the same cycle -> flush_idex=1, pc_write=1; next edge instr_out=0x00000013, valid_out=0; flush_cnt=1, stall_cnt unchanged.
- Back-to-back branches: branch_taken=1 for two consecutive cycles -> two FLUSH cycles, flush_cnt=2, issue_cnt unchanged.
- Saturation: force 0xFFFF+2 bubbles with CNT_W=16 -> stall_cnt holds at 0xFFFF.
